// File: rtl/instr_feeder.sv
// Instruction feeder / sequencer for the lab CPU.
// Buffers 16-bit instructions in a small FIFO and drives the CPU
// load/start/waiting handshake, counting completed instructions.
module instr_feeder #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_valid,
    input  logic [15:0] push_instr,
    output logic        push_ready,
    input  logic        pause,
    output logic        cpu_load,
    output logic        cpu_start,
    output logic [15:0] cpu_instr,
    input  logic        cpu_waiting,
    output logic        done,
    output logic        busy,
    output logic [7:0]  issued_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_SETTLE,
        S_EXEC
    } state_t;

    state_t        state;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          done_r;
    logic [7:0]    issued_r;
    logic          push_fire;
    logic          pop_fire;

    assign push_ready = (count < FULL_COUNT);
    assign push_fire  = push_valid & push_ready;
    assign pop_fire   = (state == S_LOAD);

    // FIFO storage: written on accepted pushes only, contents need no reset
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= push_instr;
        end
    end

    // FIFO pointers and occupancy; pop is the end of the S_LOAD cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_fire, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sequencer: issue one instruction at a time, registered done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            done_r   <= 1'b0;
            issued_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if ((count != '0) && cpu_waiting && !pause) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD:   state <= S_START;
                S_START:  state <= S_SETTLE;
                S_SETTLE: state <= S_EXEC;
                S_EXEC: begin
                    if (cpu_waiting) begin
                        done_r   <= 1'b1;
                        issued_r <= issued_r + 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output decodes of registered state and occupancy only
    always_comb begin
        cpu_load     = (state == S_LOAD);
        cpu_start    = (state == S_START);
        cpu_instr    = (state == S_LOAD) ? mem[rd_ptr] : '0;
        done         = done_r;
        busy         = (state != S_IDLE) || (count != '0);
        issued_count = issued_r;
    end

endmodule

// File: tb/tb_instr_feeder.sv
// Directed testbench for instr_feeder with a simple CPU latency model.
module tb_instr_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push_valid = 1'b0;
    logic [15:0] push_instr = '0;
    logic        push_ready;
    logic        pause = 1'b0;
    logic        cpu_load;
    logic        cpu_start;
    logic [15:0] cpu_instr;
    logic        cpu_waiting = 1'b1;
    logic        done;
    logic        busy;
    logic [7:0]  issued_count;

    int n_vec = 0;
    int n_err = 0;

    int cpu_n = 3;
    int cpu_left = 0;
    int load_cnt = 0;
    int done_cnt = 0;
    logic [15:0] load_log[$];

    instr_feeder #(.DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .push_valid(push_valid),
        .push_instr(push_instr),
        .push_ready(push_ready),
        .pause(pause),
        .cpu_load(cpu_load),
        .cpu_start(cpu_start),
        .cpu_instr(cpu_instr),
        .cpu_waiting(cpu_waiting),
        .done(done),
        .busy(busy),
        .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    // CPU model: waiting drops the cycle after start, returns cpu_n cycles later
    always @(posedge clk) begin
        if (cpu_start) begin
            cpu_waiting <= 1'b0;
            cpu_left    <= cpu_n;
        end else if (!cpu_waiting) begin
            if (cpu_left <= 1) cpu_waiting <= 1'b1;
            else cpu_left <= cpu_left - 1;
        end
    end

    // Event monitor: sees pre-edge values of the outputs
    always @(posedge clk) begin
        if (cpu_load) begin
            load_cnt = load_cnt + 1;
            load_log.push_back(cpu_instr);
        end
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        load_cnt = 0;
        done_cnt = 0;
        load_log.delete();
    endtask

    task automatic push_word(input logic [15:0] w);
        int t = 0;
        @(negedge clk);
        while (!push_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("push_timeout", 32'(t), 32'd0);
        push_valid = 1'b1;
        push_instr = w;
        @(negedge clk);
        push_valid = 1'b0;
    endtask

    task automatic wait_load(input string tag);
        int t = 0;
        @(negedge clk);
        while (!cpu_load && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check(tag, 32'(cpu_load), 32'd1);
    endtask

    task automatic wait_dones(input int target, input int max_cyc, input string tag);
        int t = 0;
        while (done_cnt < target && t < max_cyc) begin
            @(negedge clk);
            t++;
        end
        check(tag, 32'(done_cnt), 32'(target));
    endtask

    initial begin
        int t;

        // ---- reset values, asserted asynchronously from a full FIFO ----
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pause = 1'b1;
        for (int i = 0; i < 4; i++) push_word(16'h1000 + 16'(i));
        check("full_before_rst", 32'(push_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("rst_push_ready", 32'(push_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_issued", 32'(issued_count), 32'd0);
        check("rst_ctrl", {29'd0, cpu_load, cpu_start, done}, 32'd0);
        check("rst_instr", 32'(cpu_instr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pause = 1'b0;
        load_cnt = 0;
        done_cnt = 0;
        load_log.delete();

        // ---- single instruction, CPU busy for 3 cycles ----
        cpu_n = 3;
        push_word(16'hD105);
        check("one_no_early_load", 32'(cpu_load), 32'd0);
        wait_load("one_load_timeout");
        check("one_load_instr", 32'(cpu_instr), 32'hD105);
        @(negedge clk);
        check("one_start", {30'd0, cpu_start, cpu_load}, 32'd2);
        check("one_instr_zero", 32'(cpu_instr), 32'd0);
        t = 1;
        while (!done && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("one_done_latency", 32'(t), 32'd6);
        check("one_issued", 32'(issued_count), 32'd1);
        check("one_busy_low", 32'(busy), 32'd0);
        @(negedge clk);
        check("one_done_pulse", 32'(done), 32'd0);

        // ---- full FIFO with pause: 5th word ignored, FIFO order kept ----
        do_reset();
        cpu_n = 2;
        pause = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 5) check("full_ready_low", 32'(push_ready), 32'd0);
            push_valid = 1'b1;
            push_instr = 16'(i);
        end
        @(negedge clk);
        push_valid = 1'b0;
        check("full_pause_no_load", 32'(load_cnt), 32'd0);
        pause = 1'b0;
        wait_dones(4, 200, "full_dones");
        repeat (10) @(negedge clk);
        check("full_load_cnt", 32'(load_cnt), 32'd4);
        for (int i = 0; i < 4; i++)
            check("full_order", (i < load_log.size()) ? 32'(load_log[i]) : 32'hDEAD, 32'(i + 1));
        check("full_issued", 32'(issued_count), 32'd4);
        check("full_busy", 32'(busy), 32'd0);

        // ---- push offered during the pop cycle of a full FIFO ----
        do_reset();
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            push_valid = 1'b1;
            push_instr = 16'hA0 + 16'(i);
        end
        @(negedge clk);
        push_valid = 1'b0;
        pause = 1'b0;
        @(negedge clk);
        check("pp_load", 32'(cpu_load), 32'd1);
        check("pp_ready_in_load", 32'(push_ready), 32'd0);
        push_valid = 1'b1;
        push_instr = 16'hBEEF;
        @(negedge clk);
        check("pp_ready_after_pop", 32'(push_ready), 32'd1);
        @(negedge clk);
        push_valid = 1'b0;
        check("pp_full_again", 32'(push_ready), 32'd0);
        wait_dones(5, 300, "pp_dones");
        repeat (10) @(negedge clk);
        check("pp_load_cnt", 32'(load_cnt), 32'd5);
        check("pp_order0", (load_log.size() > 0) ? 32'(load_log[0]) : 32'hDEAD, 32'hA0);
        check("pp_order3", (load_log.size() > 3) ? 32'(load_log[3]) : 32'hDEAD, 32'hA3);
        check("pp_order4", (load_log.size() > 4) ? 32'(load_log[4]) : 32'hDEAD, 32'hBEEF);

        // ---- pause raised mid-instruction ----
        do_reset();
        cpu_n = 5;
        pause = 1'b1;
        push_word(16'h1111);
        push_word(16'h2222);
        pause = 1'b0;
        wait_load("pz_load_timeout");
        repeat (3) @(negedge clk);
        pause = 1'b1;
        wait_dones(1, 50, "pz_done");
        repeat (20) @(negedge clk);
        check("pz_no_load", 32'(load_cnt), 32'd1);
        check("pz_busy_queued", 32'(busy), 32'd1);
        pause = 1'b0;
        wait_load("pz_resume_timeout");
        check("pz_resume_instr", 32'(cpu_instr), 32'h2222);
        wait_dones(2, 50, "pz_done2");

        // ---- reset in S_EXEC with 2 entries queued ----
        do_reset();
        cpu_n = 8;
        pause = 1'b1;
        push_word(16'h3001);
        push_word(16'h3002);
        push_word(16'h3003);
        pause = 1'b0;
        wait_load("rm_load_timeout");
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        load_cnt = 0;
        done_cnt = 0;
        repeat (30) @(negedge clk);
        check("rm_no_done", 32'(done_cnt), 32'd0);
        check("rm_no_load", 32'(load_cnt), 32'd0);
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_ready", 32'(push_ready), 32'd1);
        check("rm_issued", 32'(issued_count), 32'd0);

        // ---- issued_count wrap after 256 completions ----
        do_reset();
        cpu_n = 1;
        for (int i = 0; i < 255; i++) push_word(16'(i));
        wait_dones(255, 2000, "wrap_255_dones");
        check("wrap_255", 32'(issued_count), 32'd255);
        push_word(16'hFFFF);
        wait_dones(256, 100, "wrap_256_dones");
        check("wrap_zero", 32'(issued_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_feeder.md
# instr_feeder

Instruction feeder and sequencer for the lab CPU. It buffers 16-bit instructions from a producer in a small FIFO and drives the CPU's `load`/`start`/`waiting` handshake. Each instruction is loaded into the instruction register, started, and then watched until it completes. It sits directly in front of `cpu`, replacing manual load/start switches, and counts completed instructions.

## Interface
Parameters:
- `DEPTH`, 4, FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-high.
- `push_valid`  in  1  producer offers `push_instr`.
- `push_instr`  in  16  instruction word.
- `push_ready`  out  1  FIFO can accept; registered-count based, `count < DEPTH`.
- `pause`  in  1  while 1, no new instruction is issued; an in-flight one finishes.
- `cpu_load`  out  1  one-cycle pulse; CPU captures `cpu_instr` into its IR.
- `cpu_start`  out  1  one-cycle pulse starting execution.
- `cpu_instr`  out  16  FIFO head during S_LOAD, else 16'h0000.
- `cpu_waiting`  in  1  CPU idle/finished flag (1 = waiting).
- `done`  out  1  one-cycle pulse per completed instruction.
- `busy`  out  1  state != S_IDLE or FIFO non-empty.
- `issued_count`  out  8  completed-instruction counter.

## Operation
- FIFO: `wr_ptr`/`rd_ptr` are log2(DEPTH) bits and wrap modulo DEPTH; `count` is log2(DEPTH)+1 bits.
  - Push is accepted when `push_valid & push_ready`.
  - Pop happens only at the end of S_LOAD.
  - Simultaneous push and pop leaves `count` unchanged.
  - When full, `push_ready` = 0 and the push is ignored, even if a pop occurs in the same cycle.
- FSM states:
  - S_IDLE: go to S_LOAD when `count != 0 & cpu_waiting & !pause`; otherwise stay.
  - S_LOAD: `cpu_load` = 1, `cpu_instr` = head; pop; always go to S_START.
  - S_START: `cpu_start` = 1; always go to S_SETTLE.
  - S_SETTLE: one cycle in which `cpu_waiting` is ignored (the CPU may still show 1); always go to S_EXEC.
  - S_EXEC: stay while `cpu_waiting` = 0. On `cpu_waiting` = 1, pulse `done`, increment `issued_count` (wraps 255 -> 0), and return to S_IDLE.
- `pause` is sampled only in S_IDLE. Asserting it mid-instruction does not abort the instruction.
- Back-to-back issue: S_IDLE is always visited between instructions, so there is a minimum of one idle cycle.
- Reset (async, any state, mid-instruction included):
  - state = S_IDLE, FIFO emptied, `issued_count` = 0.
  - `cpu_load` = `cpu_start` = `done` = `busy` = 0, `cpu_instr` = 0, `push_ready` = 1.
  - An instruction in flight is abandoned and no `done` pulse is produced. FIFO contents are not preserved.

## Timing
- All outputs are combinational decodes of registered state/count. None depends combinationally on `push_valid`, `cpu_waiting` or `pause`.
- Push accepted at edge E: `count` updates at E. S_IDLE evaluates it in the following cycle, and state enters S_LOAD at edge E+1.
- `cpu_load` is high exactly one cycle; `cpu_start` is high in the next cycle.
- With an ideal CPU whose `waiting` drops the cycle after start and returns N cycles later, `done` occurs N+3 cycles after `cpu_load`.
- `done` and the `issued_count` increment are visible in the same S_EXEC cycle; the new count value appears after that edge.
- `busy` falls in the first S_IDLE cycle with an empty FIFO.

## Test plan
- Reset values: assert `rst` asynchronously between edges → outputs go to their reset values immediately, with `push_ready` = 1 and `issued_count` = 0.
- Single instruction: push 16'hD105, CPU model waiting low for 3 cycles → expect:
  - `cpu_load` with `cpu_instr` = 16'hD105, then `cpu_start` the next cycle;
  - one `done`, `issued_count` = 1, then `busy` = 0.
- Full FIFO: push 5 words with `pause` = 1 (DEPTH = 4) →
  - words 16'h0001..16'h0004 accepted, `push_ready` = 0, 5th word ignored;
  - release `pause` → issue order 0001, 0002, 0003, 0004, `issued_count` = 4.
- Push during pop: FIFO full, push offered in the S_LOAD cycle → not accepted. Offered again next cycle → accepted, `count` back to 4.
- Pause mid-instruction: raise `pause` in S_EXEC → current instruction completes with `done`, and no `cpu_load` occurs until `pause` = 0.
- Reset mid-instruction: `rst` pulse in S_EXEC with 2 entries queued → no `done`, FIFO empty, no further `cpu_load` after release. Counter wrap: 256 completions → `issued_count` = 0.
